// File: rtl/sphere_loader_pkg.sv
// Shared scene types for the sphere loader: the packed Sphere record and the
// loader FSM encoding.
`ifndef SPHERE_LOADER_PKG_SV
`define SPHERE_LOADER_PKG_SV

`define SPHERE_B     64
`define SPHERE_BYTES 8

package Types;

  typedef struct packed {
    logic [15:0] x;
    logic [14:0] y;
    logic [14:0] z;
    logic [5:0]  r;
    logic [11:0] c;
  } Sphere;

  localparam int SPHERE_B     = `SPHERE_B;
  localparam int SPHERE_BYTES = `SPHERE_BYTES;

  // Record assembly relies on the struct packing to exactly one 8-byte record
  localparam bit SPHERE_SIZE_OK = ($bits(Sphere) == SPHERE_B);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_DATA,
    S_DONE,
    S_ERR
  } load_state_e;

endpackage

`endif

// File: rtl/sphere_bank_ram.sv
// Two-bank sphere table: one write port, one registered read port. The MSB of
// each address selects the bank, the low bits select the entry.
module sphere_bank_ram
  import Types::*;
#(
  parameter int IDX_B = 3
) (
  input  logic         clk,
  input  logic         we,
  input  logic [IDX_B:0] waddr,
  input  Sphere        wdata,
  input  logic [IDX_B:0] raddr,
  output Sphere        rdata
);

  Sphere mem [0:(1 << (IDX_B + 1)) - 1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sphere_loader.sv
// Loads framed sphere records from the SPI byte stream into the back bank of a
// double-buffered table; banks swap only at the tracer's frame boundary.
module sphere_loader
  import Types::*;
#(
  parameter int MAX_SPHERES = 8,
  parameter int IDX_B       = (MAX_SPHERES > 1) ? $clog2(MAX_SPHERES) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  input  logic             frame_done,
  input  logic [IDX_B-1:0] rd_idx,
  output Sphere            rd_sphere,
  output logic [IDX_B:0]   sphere_count,
  output logic             load_err,
  output logic             pending
);

  if (!SPHERE_SIZE_OK) begin : g_sphere_size_chk
    $error("Sphere struct width does not match the 64-bit record size");
  end

  load_state_e state_q, state_d;

  logic [IDX_B:0] cnt_n_q;
  logic [IDX_B:0] rec_idx_q;
  logic [IDX_B:0] rec_nxt;
  logic [IDX_B:0] pend_count_q;
  logic [2:0]     byte_cnt_q;
  logic [55:0]    asm_q;
  logic           front_q;

  logic err_d;
  logic commit;
  logic wr_en;
  logic latch_n;
  logic shift;
  logic swap;
  logic count_ok;
  logic last_byte;

  Sphere          wr_sphere;
  logic [IDX_B:0] wr_addr;
  logic [IDX_B:0] rd_addr;
  Sphere          rd_data_p1;
  logic           rd_vld_p1;

  assign rec_nxt   = rec_idx_q + {{IDX_B{1'b0}}, 1'b1};
  assign count_ok  = (int'(byte_data) <= MAX_SPHERES);
  assign last_byte = (byte_cnt_q == 3'(SPHERE_BYTES - 1));
  // pending is the pre-edge value, so a commit in this same cycle cannot swap
  assign swap      = frame_done & pending;

  // ---- loader FSM: next state and per-cycle strobes ----
  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    commit  = 1'b0;
    wr_en   = 1'b0;
    latch_n = 1'b0;
    shift   = 1'b0;
    if (frame_start) begin
      state_d = S_COUNT;
    end else begin
      unique case (state_q)
        S_COUNT: begin
          if (frame_end) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (byte_valid) begin
            if (!count_ok) begin
              err_d   = 1'b1;
              state_d = S_ERR;
            end else begin
              latch_n = 1'b1;
              state_d = (byte_data == 8'd0) ? S_DONE : S_DATA;
            end
          end
        end
        S_DATA: begin
          if (frame_end) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else if (byte_valid) begin
            shift = 1'b1;
            if (last_byte) begin
              wr_en = 1'b1;
              if (rec_nxt == cnt_n_q) begin
                state_d = S_DONE;
              end
            end
          end
        end
        S_DONE: begin
          if (frame_end) begin
            commit  = 1'b1;
            state_d = S_IDLE;
          end else if (byte_valid) begin
            err_d   = 1'b1;
            state_d = S_ERR;
          end
        end
        S_ERR: begin
          if (frame_end) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      load_err   <= 1'b0;
      cnt_n_q    <= '0;
      rec_idx_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      load_err <= err_d;
      if (latch_n) begin
        cnt_n_q    <= (IDX_B + 1)'(byte_data);
        rec_idx_q  <= '0;
        byte_cnt_q <= '0;
      end else begin
        if (shift) begin
          byte_cnt_q <= byte_cnt_q + 3'd1;
        end
        if (wr_en) begin
          rec_idx_q <= rec_nxt;
        end
      end
    end
  end

  // Assembly register is pure data; stale contents are always overwritten
  always_ff @(posedge clk) begin
    if (shift) begin
      asm_q <= {asm_q[47:0], byte_data};
    end
  end

  // ---- commit and bank swap ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pending      <= 1'b0;
      pend_count_q <= '0;
      front_q      <= 1'b0;
      sphere_count <= '0;
    end else begin
      if (frame_start) begin
        pending <= 1'b0;
      end else if (commit) begin
        pending <= 1'b1;
      end else if (swap) begin
        pending <= 1'b0;
      end
      if (commit) begin
        pend_count_q <= cnt_n_q;
      end
      if (swap) begin
        front_q      <= ~front_q;
        sphere_count <= pend_count_q;
      end
    end
  end

  assign wr_sphere = {asm_q, byte_data};
  assign wr_addr   = {~front_q, rec_idx_q[IDX_B-1:0]};
  assign rd_addr   = {front_q, rd_idx};

  sphere_bank_ram #(
    .IDX_B (IDX_B)
  ) u_bank_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_sphere),
    .raddr (rd_addr),
    .rdata (rd_data_p1)
  );

  // ---- read stage p1: mask entries beyond the front-bank count ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_vld_p1 <= 1'b0;
    end else begin
      rd_vld_p1 <= ({1'b0, rd_idx} < sphere_count);
    end
  end

  assign rd_sphere = rd_vld_p1 ? rd_data_p1 : '0;

endmodule

// File: tb/tb_sphere_loader.sv
// Directed bench for sphere_loader: loads, rejects, same-cycle events, reset.
module tb_sphere_loader;
  import Types::*;

  localparam int MAXS = 8;
  localparam int IB   = 3;

  localparam logic [63:0] REC_A = 64'h0010_0020_0030_0A05;
  localparam logic [63:0] REC_B = 64'hFFF0_0008_0100_3FFF;
  localparam logic [63:0] REC_C = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] REC_D = 64'h0BAD_F00D_CAFE_0001;
  localparam logic [63:0] REC_F = 64'hAAAA_5555_0F0F_F0F0;
  localparam logic [63:0] REC_E = 64'h0102_0304_0506_0708;

  logic          clk = 1'b0;
  logic          rstn;
  logic          frame_start;
  logic          frame_end;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          frame_done;
  logic [IB-1:0] rd_idx;
  Sphere         rd_sphere;
  logic [IB:0]   sphere_count;
  logic          load_err;
  logic          pending;

  int vecs        = 0;
  int miscompares = 0;
  int err_cnt     = 0;

  always #5 clk = ~clk;

  sphere_loader #(
    .MAX_SPHERES (MAXS),
    .IDX_B       (IB)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .frame_start  (frame_start),
    .frame_end    (frame_end),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .frame_done   (frame_done),
    .rd_idx       (rd_idx),
    .rd_sphere    (rd_sphere),
    .sphere_count (sphere_count),
    .load_err     (load_err),
    .pending      (pending)
  );

  // Tally every load_err pulse, sampled just after the edge that produces it
  always @(posedge clk) begin
    #1;
    if (load_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
    byte_data  = 8'h00;
  endtask

  task automatic send_rec(input logic [63:0] v);
    for (int i = 7; i >= 0; i--) send_byte(v[i*8 +: 8]);
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic pulse_fe();
    frame_end = 1'b1;
    @(negedge clk);
    frame_end = 1'b0;
  endtask

  task automatic pulse_fd();
    frame_done = 1'b1;
    @(negedge clk);
    frame_done = 1'b0;
  endtask

  task automatic do_read(input logic [IB-1:0] idx, output logic [63:0] v);
    rd_idx = idx;
    @(negedge clk);
    v = rd_sphere;
  endtask

  initial begin
    logic [63:0] rv;
    rstn        = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
    frame_done  = 1'b0;
    rd_idx      = '0;
    repeat (2) @(negedge clk);

    chk("rst_rd_sphere", rd_sphere, 64'h0);
    chk("rst_count", 64'(sphere_count), 64'd0);
    chk("rst_load_err", 64'(load_err), 64'd0);
    chk("rst_pending", 64'(pending), 64'd0);
    rstn = 1'b1;
    @(negedge clk);

    // Normal load, N=2
    pulse_fs();
    send_byte(8'd2);
    send_rec(REC_A);
    send_rec(REC_B);
    pulse_fe();
    chk("load1_pending", 64'(pending), 64'd1);
    chk("load1_count_preswap", 64'(sphere_count), 64'd0);
    do_read(0, rv);
    chk("load1_rd0_preswap", rv, 64'h0);
    pulse_fd();
    chk("load1_count", 64'(sphere_count), 64'd2);
    chk("load1_pending_clr", 64'(pending), 64'd0);
    do_read(0, rv);
    chk("load1_rd0", rv, REC_A);
    do_read(1, rv);
    chk("load1_rd1", rv, REC_B);
    do_read(2, rv);
    chk("load1_rd2_masked", rv, 64'h0);
    chk("load1_no_err", 64'(err_cnt), 64'd0);

    // Second load stays hidden until frame_done
    pulse_fs();
    send_byte(8'd1);
    send_rec(REC_C);
    pulse_fe();
    chk("load2_pending", 64'(pending), 64'd1);
    chk("load2_count_held", 64'(sphere_count), 64'd2);
    do_read(0, rv);
    chk("load2_rd0_held", rv, REC_A);
    pulse_fd();
    chk("load2_count", 64'(sphere_count), 64'd1);
    do_read(0, rv);
    chk("load2_rd0", rv, REC_C);
    do_read(1, rv);
    chk("load2_rd1_masked", rv, 64'h0);

    // Truncated frame: N=2 but only 11 record bytes
    pulse_fs();
    send_byte(8'd2);
    send_rec(REC_A);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    pulse_fe();
    chk("trunc_err", 64'(err_cnt), 64'd1);
    chk("trunc_pending", 64'(pending), 64'd0);
    pulse_fd();
    chk("trunc_count", 64'(sphere_count), 64'd1);
    do_read(0, rv);
    chk("trunc_rd0", rv, REC_C);

    // Count above MAX_SPHERES; remaining bytes ignored
    pulse_fs();
    send_byte(8'd9);
    send_rec(REC_B);
    pulse_fe();
    chk("n9_err", 64'(err_cnt), 64'd2);
    chk("n9_pending", 64'(pending), 64'd0);
    pulse_fd();
    chk("n9_count", 64'(sphere_count), 64'd1);

    // One extra byte after a complete frame
    pulse_fs();
    send_byte(8'd1);
    send_rec(REC_D);
    send_byte(8'h55);
    pulse_fe();
    chk("extra_err", 64'(err_cnt), 64'd3);
    chk("extra_pending", 64'(pending), 64'd0);
    pulse_fd();
    chk("extra_count", 64'(sphere_count), 64'd1);
    do_read(0, rv);
    chk("extra_rd0", rv, REC_C);

    // Commit coincident with frame_done: swap deferred
    pulse_fs();
    send_byte(8'd2);
    send_rec(REC_A);
    send_rec(REC_B);
    frame_end  = 1'b1;
    frame_done = 1'b1;
    @(negedge clk);
    frame_end  = 1'b0;
    frame_done = 1'b0;
    chk("coinc_pending", 64'(pending), 64'd1);
    chk("coinc_count_held", 64'(sphere_count), 64'd1);
    pulse_fd();
    chk("coinc_count", 64'(sphere_count), 64'd2);
    chk("coinc_pending_clr", 64'(pending), 64'd0);
    do_read(1, rv);
    chk("coinc_rd1", rv, REC_B);

    // frame_start coincident with frame_done while pending
    pulse_fs();
    send_byte(8'd1);
    send_rec(REC_F);
    pulse_fe();
    chk("fsfd_pending_pre", 64'(pending), 64'd1);
    frame_start = 1'b1;
    frame_done  = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    frame_done  = 1'b0;
    chk("fsfd_pending", 64'(pending), 64'd0);
    chk("fsfd_count", 64'(sphere_count), 64'd1);
    send_byte(8'd1);
    send_rec(REC_E);
    pulse_fe();
    chk("fsfd_pending2", 64'(pending), 64'd1);
    do_read(0, rv);
    chk("fsfd_rd0_front", rv, REC_F);
    pulse_fd();
    do_read(0, rv);
    chk("fsfd_rd0_new", rv, REC_E);
    chk("fsfd_no_new_err", 64'(err_cnt), 64'd3);

    // Reset in the middle of DATA
    rd_idx = '0;
    pulse_fs();
    send_byte(8'd2);
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    rstn = 1'b0;
    #1;
    chk("mrst_rd_sphere", rd_sphere, 64'h0);
    chk("mrst_count", 64'(sphere_count), 64'd0);
    chk("mrst_pending", 64'(pending), 64'd0);
    chk("mrst_load_err", 64'(load_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    pulse_fs();
    send_byte(8'd0);
    pulse_fe();
    chk("n0_pending", 64'(pending), 64'd1);
    pulse_fd();
    chk("n0_count", 64'(sphere_count), 64'd0);
    do_read(0, rv);
    chk("n0_rd0", rv, 64'h0);
    do_read(1, rv);
    chk("n0_rd1", rv, 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
    $finish;
  end

endmodule
